// File: rtl/data_unit.sv
// Operand-fetch / write-back slice: 8x16 register file, A/B operand latches,
// write-back mux and immediate generator with UI register. Optional macro: DATA_BYPASS_EN.
module data_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [$clog2(NUM_REGS)-1:0]   input_reg_readA_address,
    input  logic [$clog2(NUM_REGS)-1:0]   input_reg_readB_address,
    input  logic                          input_reg_write,
    input  logic [$clog2(NUM_REGS)-1:0]   input_reg_write_address,
    input  logic [DATA_WIDTH-1:0]         input_imm,
    input  logic [DATA_WIDTH-1:0]         input_ALUOut,
    input  logic [DATA_WIDTH-1:0]         input_MDR,
    input  logic                          memToReg,
    output logic [DATA_WIDTH-1:0]         output_reg_A,
    output logic [DATA_WIDTH-1:0]         output_reg_B,
    output logic [DATA_WIDTH-1:0]         output_imm
);

    localparam int unsigned UI_W     = 10;
    localparam int unsigned SE7_PAD  = DATA_WIDTH - 7;
    localparam int unsigned SE13_PAD = DATA_WIDTH - 13;

    localparam logic [2:0] OP_2RI = 3'b001;
    localparam logic [2:0] OP_RI  = 3'b010;
    localparam logic [2:0] OP_L   = 3'b011;
    localparam logic [2:0] OP_UJ  = 3'b100;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [UI_W-1:0]       r_ui;

    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_ui_load;

    // Write-back source and operand read (optionally forwarding the write data)
    always_comb begin
        w_wdata = memToReg ? input_MDR : input_ALUOut;
        w_rd_a  = r_regs[input_reg_readA_address];
        w_rd_b  = r_regs[input_reg_readB_address];
`ifdef DATA_BYPASS_EN
        if (input_reg_write && (input_reg_write_address == input_reg_readA_address)) begin
            w_rd_a = w_wdata;
        end
        if (input_reg_write && (input_reg_write_address == input_reg_readB_address)) begin
            w_rd_b = w_wdata;
        end
`endif
    end

    // Immediate decode; RI concatenates the currently held UI
    always_comb begin
        w_imm     = '0;
        w_ui_load = 1'b0;
        case (input_imm[2:0])
            OP_2RI:  w_imm = DATA_WIDTH'({{SE7_PAD{input_imm[15]}}, input_imm[15:9]});
            OP_RI:   w_imm = DATA_WIDTH'({r_ui, input_imm[11:6]});
            OP_L:    w_ui_load = 1'b1;
            OP_UJ:   w_imm = DATA_WIDTH'({{SE13_PAD{input_imm[15]}}, input_imm[15:3]});
            default: w_imm = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (input_reg_write) begin
            r_regs[input_reg_write_address] <= w_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ui <= '0;
        end else if (w_ui_load) begin
            r_ui <= input_imm[15:6];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            output_reg_A <= '0;
            output_reg_B <= '0;
            output_imm   <= '0;
        end else begin
            output_reg_A <= w_rd_a;
            output_reg_B <= w_rd_b;
            output_imm   <= w_imm;
        end
    end

endmodule

// File: tb/tb_data_unit.sv
// Self-checking bench for data_unit: reference model feeds a scoreboard queue,
// each scenario task pops and compares after the latching edge.
module tb_data_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ra, rb, wa;
    logic        we, mem;
    logic [15:0] imm, alu, mdr;
    logic [15:0] o_a, o_b, o_imm;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] m_regs [8];
    logic [9:0]  m_ui;
    int          n_checks;
    int          n_errors;

    data_unit dut (
        .CLK                     (clk),
        .RST_N                   (rst_n),
        .input_reg_readA_address (ra),
        .input_reg_readB_address (rb),
        .input_reg_write         (we),
        .input_reg_write_address (wa),
        .input_imm               (imm),
        .input_ALUOut            (alu),
        .input_MDR               (mdr),
        .memToReg                (mem),
        .output_reg_A            (o_a),
        .output_reg_B            (o_b),
        .output_imm              (o_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predict this cycle's outputs, update the model, then advance one edge
    task automatic drive_cycle();
        exp_t        e;
        logic [15:0] wd;
        wd  = mem ? mdr : alu;
        e.a = m_regs[ra];
        e.b = m_regs[rb];
`ifdef DATA_BYPASS_EN
        if (we && wa == ra) e.a = wd;
        if (we && wa == rb) e.b = wd;
`endif
        case (imm[2:0])
            3'b001:  e.imm = {{9{imm[15]}}, imm[15:9]};
            3'b010:  e.imm = {m_ui, imm[11:6]};
            3'b100:  e.imm = {{3{imm[15]}}, imm[15:3]};
            default: e.imm = 16'h0000;
        endcase
        if (imm[2:0] == 3'b011) m_ui = imm[15:6];
        if (we) m_regs[wa] = wd;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_ui = 10'h000;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        ra = 3'd3; rb = 3'd3; wa = 3'd0; we = 1'b0; mem = 1'b0;
        imm = 16'h0000; alu = 16'h0000; mdr = 16'h0000;
        model_reset();
        #1;
        n_checks++; if (o_a !== 16'h0000) begin n_errors++; $display("FAIL reset_A got=%h exp=0000", o_a); end
        n_checks++; if (o_b !== 16'h0000) begin n_errors++; $display("FAIL reset_B got=%h exp=0000", o_b); end
        n_checks++; if (o_imm !== 16'h0000) begin n_errors++; $display("FAIL reset_imm got=%h exp=0000", o_imm); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_a !== e.a) begin n_errors++; $display("FAIL reset_read3_A got=%h exp=%h", o_a, e.a); end
        n_checks++; if (o_b !== e.b) begin n_errors++; $display("FAIL reset_read3_B got=%h exp=%h", o_b, e.b); end
    endtask

    task automatic test_mdr_write();
        exp_t        e;
        logic [15:0] vals [3];
        vals[0] = 16'h0001; vals[1] = 16'h0005; vals[2] = 16'h0010;
        mem = 1'b1; we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wa  = 3'(i);
            mdr = vals[i];
            alu = 16'hDEAD;
            drive_cycle();
            void'(sb.pop_front());
        end
        we = 1'b0; ra = 3'd0; rb = 3'd1;
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_a !== e.a || o_a !== 16'h0001) begin n_errors++; $display("FAIL mdr_r0 got=%h exp=%h", o_a, e.a); end
        n_checks++; if (o_b !== e.b || o_b !== 16'h0005) begin n_errors++; $display("FAIL mdr_r1 got=%h exp=%h", o_b, e.b); end
        ra = 3'd2;
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_a !== e.a || o_a !== 16'h0010) begin n_errors++; $display("FAIL mdr_r2 got=%h exp=%h", o_a, e.a); end
    endtask

    task automatic test_alu_write();
        exp_t e;
        mem = 1'b0; alu = 16'h1234; mdr = 16'hBEEF;
        we = 1'b1; wa = 3'd2; ra = 3'd2; rb = 3'd0;
        drive_cycle();
        e = sb.pop_front();
`ifdef DATA_BYPASS_EN
        n_checks++; if (o_a !== e.a || o_a !== 16'h1234) begin n_errors++; $display("FAIL same_cycle_r2 got=%h exp=%h", o_a, e.a); end
`else
        n_checks++; if (o_a !== e.a || o_a !== 16'h0010) begin n_errors++; $display("FAIL same_cycle_r2 got=%h exp=%h", o_a, e.a); end
`endif
        n_checks++; if (o_b !== e.b) begin n_errors++; $display("FAIL same_cycle_r0 got=%h exp=%h", o_b, e.b); end
        we = 1'b0;
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_a !== e.a || o_a !== 16'h1234) begin n_errors++; $display("FAIL alu_r2 got=%h exp=%h", o_a, e.a); end
    endtask

    task automatic test_imm();
        exp_t        e;
        logic [15:0] pats [4];
        logic [15:0] want [4];
        pats[0] = 16'h8001; want[0] = 16'hFFC0;
        pats[1] = 16'h006C; want[1] = 16'h000D;
        pats[2] = 16'hFFF8; want[2] = 16'h0000;
        pats[3] = 16'hFFFD; want[3] = 16'h0000;
        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imm = pats[i];
            drive_cycle();
            e = sb.pop_front();
            n_checks++;
            if (o_imm !== e.imm || o_imm !== want[i]) begin
                n_errors++; $display("FAIL imm_%0d in=%h got=%h exp=%h", i, pats[i], o_imm, want[i]);
            end
        end
    endtask

    task automatic test_ui();
        exp_t e;
        we = 1'b0;
        imm = 16'hFFC3;
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_imm !== e.imm || o_imm !== 16'h0000) begin n_errors++; $display("FAIL ui_load_imm got=%h exp=0000", o_imm); end
        imm = 16'h0042;
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_imm !== e.imm || o_imm !== 16'hFFC1) begin n_errors++; $display("FAIL ui_ri got=%h exp=FFC1", o_imm); end
        imm = 16'h0000;
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_imm !== e.imm) begin n_errors++; $display("FAIL ui_3r got=%h exp=%h", o_imm, e.imm); end
        imm = 16'h0042;
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_imm !== e.imm || o_imm !== 16'hFFC1) begin n_errors++; $display("FAIL ui_hold got=%h exp=FFC1", o_imm); end
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_imm !== e.imm || o_imm !== 16'h0001) begin n_errors++; $display("FAIL ui_after_reset got=%h exp=0001", o_imm); end
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        imm = 16'h0000; mem = 1'b0;
        we = 1'b1; wa = 3'd5; alu = 16'h7777; ra = 3'd0; rb = 3'd0;
        drive_cycle();
        void'(sb.pop_front());
        ra = 3'd5; rb = 3'd5; alu = 16'hBEEF; imm = 16'h8001;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++; if (o_a !== 16'h0000) begin n_errors++; $display("FAIL midrst_A got=%h exp=0000", o_a); end
        n_checks++; if (o_imm !== 16'h0000) begin n_errors++; $display("FAIL midrst_imm got=%h exp=0000", o_imm); end
        @(negedge clk);
        rst_n = 1'b1;
        we = 1'b0; imm = 16'h0000;
        drive_cycle();
        e = sb.pop_front();
        n_checks++; if (o_a !== e.a || o_a !== 16'h0000) begin n_errors++; $display("FAIL midrst_r5_A got=%h exp=0000", o_a); end
        n_checks++; if (o_b !== e.b || o_b !== 16'h0000) begin n_errors++; $display("FAIL midrst_r5_B got=%h exp=0000", o_b); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rb  = 3'($urandom_range(0, 7));
            wa  = 3'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            mem = 1'($urandom_range(0, 1));
            alu = 16'($urandom);
            mdr = 16'($urandom);
            imm = 16'($urandom);
            drive_cycle();
            e = sb.pop_front();
            n_checks++; if (o_a !== e.a) begin n_errors++; $display("FAIL b2b_A[%0d] got=%h exp=%h", i, o_a, e.a); end
            n_checks++; if (o_b !== e.b) begin n_errors++; $display("FAIL b2b_B[%0d] got=%h exp=%h", i, o_b, e.b); end
            n_checks++; if (o_imm !== e.imm) begin n_errors++; $display("FAIL b2b_imm[%0d] got=%h exp=%h", i, o_imm, e.imm); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_mdr_write();
        test_alu_write();
        test_imm();
        test_ui();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_unit.md
Name: data_unit

Overview:
Operand-fetch and write-back slice of the 16-bit multi-cycle processor datapath.
- Contains an 8 x 16 register file and the A/B operand latches.
- Contains the write-back source mux (ALUOut vs MDR).
- Contains an immediate generator with a 10-bit upper-immediate (UI) register.
- Sits between the instruction register / control FSM and the ALU operand muxes.

Parameters:
DATA_WIDTH, 16, datapath width; the immediate formats below are defined for 16 only.
NUM_REGS, 8, register count; addressed by 3 bits.

Ports:
CLK  in  1  system clock; all state updates on rising edge.
RST_N  in  1  asynchronous active-low reset.
input_reg_readA_address  in  3  source register for A.
input_reg_readB_address  in  3  source register for B.
input_reg_write  in  1  register-file write enable.
input_reg_write_address  in  3  destination register.
input_imm  in  16  current instruction word, used by the immediate generator.
input_ALUOut  in  16  ALU result write-back source.
input_MDR  in  16  memory data register write-back source.
memToReg  in  1  write-back select: 1 = MDR, 0 = ALUOut.
output_reg_A  out  16  latched register operand A.
output_reg_B  out  16  latched register operand B.
output_imm  out  16  latched generated immediate.

Behaviour:
Reset (RST_N low, asynchronous):
- All 8 registers, UI, output_reg_A, output_reg_B and output_imm are cleared to 0.
- Reset held low overrides any write in progress.

Write-back:
- wdata = memToReg ? input_MDR : input_ALUOut.
- At a rising edge with input_reg_write = 1: reg[input_reg_write_address] <= wdata.
- r0 is an ordinary writable register (not hardwired to zero).

Operand read:
- Every rising edge: output_reg_A <= reg[readA]; output_reg_B <= reg[readB].
- Read-before-write: when a read address equals the write address in the same cycle, the old value is latched (unless BYPASS_EN is defined).
- Latency is 1 cycle from address to output. Outputs hold between edges.

Immediate generator (opcode = input_imm[2:0]); output_imm is registered every edge:
- 000 3R: 0.
- 001 2RI: sign-extend input_imm[15:9].
- 010 RI: {UI, input_imm[11:6]}.
- 011 L: output 0; additionally UI <= input_imm[15:6] on the same edge.
- 100 UJ: sign-extend input_imm[15:3].
- 101, 110, 111: 0 (reserved).

UI register:
- Holds its value until the next L-type instruction or reset.
- An RI in the cycle immediately following an L-type uses the newly latched UI.

Optional Feature:
DATA_BYPASS_EN
- Defined: if input_reg_write = 1 and the write address equals readA (or readB), output_reg_A (or B) latches wdata on that edge instead of the old register content.
- Undefined: strict read-before-write as described above.
- All other behaviour is identical in both builds.

Test Plan:
1. RST_N low, then high; no writes -> output_reg_A = output_reg_B = output_imm = 0; readA = readB = 3 gives 0.
2. Write r0 = 0x0001, r1 = 0x0005, r2 = 0x0010 via MDR (memToReg = 1); then readA = 0, readB = 1 -> after 1 edge A = 0x0001, B = 0x0005; readA = 2 -> A = 0x0010.
3. memToReg = 0, ALUOut = 0x1234, write r2; next cycle readA = 2 -> A = 0x1234. Same-cycle read/write of r2 gives old 0x0010 without DATA_BYPASS_EN, 0x1234 with it.
4. input_imm = 0x8001 (2RI, [15:9] = 1000000) -> imm = 0xFFC0. input_imm = 0x006C (UJ, [15:3] = 13) -> imm = 0x000D.
5. L-type input_imm = 0xFFC3 -> imm = 0 and UI = 0x3FF; next cycle RI input_imm = 0x0042 ([11:6] = 1) -> imm = 0xFFC1. Reset then the same RI -> imm = 0x0001.
6. Assert RST_N low mid-write with input_reg_write = 1 -> target register and all outputs read 0 after release.
